pipe_stage_latch: RTL and testbench

//   Parametrised inter-stage pipeline latch (F/D, D/X, X/M, M/W) carrying NUM_FIELDS packed

---
 rtl/cpu_pipe_pkg.sv | 14 +
 rtl/pipe_stage_latch_if.sv | 24 ++
 rtl/reg_nbit.sv | 21 ++
 rtl/pipe_stage_latch.sv | 95 +++++++++
 tb/tb_pipe_stage_latch.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared field indices and defaults for the pipeline latches
package cpu_pipe_pkg;

    localparam int FIELD_PC = 0;
    localparam int FIELD_IR = 1;
    localparam int FIELD_A  = 2;
    localparam int FIELD_B  = 3;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_NUM_FIELDS = 4;

    localparam logic [DEF_WIDTH-1:0] NOP_INSN = 32'b0;

endpackage

// File: rtl/pipe_stage_latch_if.sv
// rtl/pipe_stage_latch_if.sv - valid/ready bundle around one pipeline latch
interface pipe_stage_latch_if
    import cpu_pipe_pkg::*;
#(
    parameter int DW = DEF_WIDTH * DEF_NUM_FIELDS
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    // master is the surrounding pipeline (drives upstream data, downstream ready)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/reg_nbit.sv
// rtl/reg_nbit.sv - parametrised register with synchronous reset to a constant
module reg_nbit #(
    parameter int           N           = 32,
    parameter logic [N-1:0] RESET_VALUE = '0
) (
    input  logic         clock,
    input  logic         ctrl_writeEnable,
    input  logic         ctrl_reset,
    input  logic [N-1:0] data_writeReg,
    output logic [N-1:0] data_readReg
);

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            data_readReg <= RESET_VALUE;
        end else if (ctrl_writeEnable) begin
            data_readReg <= data_writeReg;
        end
    end

endmodule

// File: rtl/pipe_stage_latch.sv
// rtl/pipe_stage_latch.sv - inter-stage latch with skid buffer, flush bubble and stall counter
module pipe_stage_latch
    import cpu_pipe_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               NUM_FIELDS = DEF_NUM_FIELDS,
    parameter int               NOP_FIELD  = FIELD_IR,
    parameter logic [WIDTH-1:0] NOP_VALUE  = NOP_INSN,
    parameter int               CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_latch_if.slave    bus,
    output logic [CNT_W-1:0]     stall_count
);

    localparam int             DW     = WIDTH * NUM_FIELDS;
    localparam logic [DW-1:0]  BUBBLE = DW'(NOP_VALUE) << (NOP_FIELD * WIDTH);

    logic          w_out_valid;
    logic          w_skid_valid;
    logic [DW-1:0] w_main_data;
    logic [DW-1:0] w_skid_data;
    logic          w_acc;
    logic          w_pop;
    logic          w_main_load;
    logic          w_main_we;
    logic          w_skid_we;
    logic          w_out_valid_d;
    logic          w_skid_valid_d;
    logic [DW-1:0] w_main_d;
    logic          w_kill;
    logic [CNT_W-1:0] r_stall_count;

    assign bus.in_ready  = !w_skid_valid && !reset;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_main_data;

    assign w_acc  = bus.in_valid && bus.in_ready;
    assign w_pop  = w_out_valid && bus.out_ready;
    assign w_kill = reset || flush;

    // Main refills when empty or draining; the skid entry always goes first to keep order.
    assign w_main_load    = !w_out_valid || w_pop;
    assign w_main_we      = w_main_load && (w_skid_valid || w_acc);
    assign w_main_d       = w_skid_valid ? w_skid_data : bus.in_data;
    assign w_out_valid_d  = w_main_load ? (w_skid_valid || w_acc) : 1'b1;
    assign w_skid_we      = !w_main_load && w_acc;
    assign w_skid_valid_d = w_main_load ? 1'b0 : (w_skid_valid || w_acc);

    reg_nbit #(.N(DW), .RESET_VALUE(BUBBLE)) u_main_data (
        .clock            (clock),
        .ctrl_writeEnable (w_main_we),
        .ctrl_reset       (w_kill),
        .data_writeReg    (w_main_d),
        .data_readReg     (w_main_data)
    );

    reg_nbit #(.N(DW), .RESET_VALUE('0)) u_skid_data (
        .clock            (clock),
        .ctrl_writeEnable (w_skid_we),
        .ctrl_reset       (reset),
        .data_writeReg    (bus.in_data),
        .data_readReg     (w_skid_data)
    );

    reg_nbit #(.N(1), .RESET_VALUE(1'b0)) u_out_valid (
        .clock            (clock),
        .ctrl_writeEnable (1'b1),
        .ctrl_reset       (w_kill),
        .data_writeReg    (w_out_valid_d),
        .data_readReg     (w_out_valid)
    );

    reg_nbit #(.N(1), .RESET_VALUE(1'b0)) u_skid_valid (
        .clock            (clock),
        .ctrl_writeEnable (1'b1),
        .ctrl_reset       (w_kill),
        .data_writeReg    (w_skid_valid_d),
        .data_readReg     (w_skid_valid)
    );

    // Performance counter survives flush; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_out_valid && !bus.out_ready && !(&r_stall_count)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb/tb_pipe_stage_latch.sv - scoreboard bench for pipe_stage_latch
module tb_pipe_stage_latch;

    localparam int WIDTH      = 32;
    localparam int NUM_FIELDS = 4;
    localparam int DW         = WIDTH * NUM_FIELDS;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clock;
    logic             reset;
    logic             flush;
    logic [CNT_W-1:0] stall_count;

    pipe_stage_latch_if #(.DW(DW)) bus ();

    pipe_stage_latch #(
        .WIDTH      (WIDTH),
        .NUM_FIELDS (NUM_FIELDS),
        .NOP_FIELD  (1),
        .NOP_VALUE  (32'h0),
        .CNT_W      (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .bus         (bus.slave),
        .stall_count (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    int            exp_cnt    = 0;
    bit            exp_bubble = 1'b1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: the latch is a FIFO of depth two; empty flush/reset leaves an all-zero bubble.
    always @(negedge clock) begin
        bit acc;
        chk("in_ready", DW'(bus.in_ready), DW'(!reset && exp_q.size() < 2));
        chk("out_valid", DW'(bus.out_valid), DW'(exp_q.size() > 0));
        if (exp_q.size() > 0)
            chk("out_data", bus.out_data, exp_q[0]);
        else if (exp_bubble)
            chk("bubble_data", bus.out_data, '0);
        chk("stall_count", DW'(stall_count), DW'(exp_cnt));

        if (reset) begin
            exp_q.delete();
            exp_cnt    = 0;
            exp_bubble = 1'b1;
        end else begin
            acc = bus.in_valid && (exp_q.size() < 2);
            if (exp_q.size() > 0 && !bus.out_ready && exp_cnt < CNT_MAX)
                exp_cnt++;
            if (exp_q.size() > 0 && bus.out_ready)
                void'(exp_q.pop_front());
            if (flush) begin
                exp_q.delete();
                exp_bubble = 1'b1;
            end else if (acc) begin
                exp_q.push_back(bus.in_data);
            end
            if (exp_q.size() > 0)
                exp_bubble = 1'b0;
        end
    end

    task automatic step(input bit r, input bit fl, input bit iv, input bit ordy, input logic [31:0] pc);
        reset         = r;
        flush         = fl;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.in_data   = {$urandom(), $urandom(), $urandom(), iv ? pc : $urandom()};
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;

        step(1, 0, 1, 0, 32'h1);
        step(1, 0, 1, 0, 32'h2);
        step(0, 0, 0, 1, 32'h0);

        step(0, 0, 1, 1, 32'h10);
        step(0, 0, 1, 1, 32'h14);
        step(0, 0, 1, 1, 32'h18);
        step(0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 1, 32'h0);

        step(0, 0, 1, 0, 32'hA0);
        step(0, 0, 1, 0, 32'hB0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'hC0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'h0);

        step(0, 0, 1, 0, 32'hA1);
        step(0, 0, 1, 0, 32'hB1);
        step(0, 1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0);

        step(0, 0, 1, 0, 32'h50);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 32'h0);

        step(0, 1, 1, 1, 32'h60);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 500) % 3;
            step(($urandom() % 300) == 0,
                 ($urandom() % 30) == 0,
                 $urandom() % 3 != 0,
                 (bias == 0) ? ($urandom() % 4 != 0) :
                 (bias == 1) ? ($urandom() % 2 == 0) : ($urandom() % 5 == 0),
                 $urandom());
        end

        step(0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 1, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
